// File: rtl/arm_pkg.sv
// Shared ARM core definitions: condition codes, flag bit positions and the
// ALU command width used by decode, execute and the branch predictor.
package arm_pkg;

    localparam int EXEC_CMD_W = 4;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    typedef struct packed {
        logic [EXEC_CMD_W-1:0] exec_cmd;
        logic                  mem_r_en;
        logic                  mem_w_en;
        logic                  wb_en;
        logic                  status_w_en;
        logic                  branch_taken;
    } ctrl_t;

endpackage

// File: rtl/cond_check.sv
// Evaluates an ARM condition field against the {N,Z,C,V} flags.
// Purely combinational so the IF-stage branch predictor can reuse it.
module cond_check
    import arm_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] status,
    output logic       cond_pass
);

    logic n, z, c, v;

    assign n = status[FLAG_N];
    assign z = status[FLAG_Z];
    assign c = status[FLAG_C];
    assign v = status[FLAG_V];

    always_comb begin
        cond_pass = 1'b0;
        case (cond)
            COND_EQ: cond_pass = z;
            COND_NE: cond_pass = !z;
            COND_CS: cond_pass = c;
            COND_CC: cond_pass = !c;
            COND_MI: cond_pass = n;
            COND_PL: cond_pass = !n;
            COND_VS: cond_pass = v;
            COND_VC: cond_pass = !v;
            COND_HI: cond_pass = c & !z;
            COND_LS: cond_pass = !c | z;
            COND_GE: cond_pass = (n == v);
            COND_LT: cond_pass = (n != v);
            COND_GT: cond_pass = !z & (n == v);
            COND_LE: cond_pass = z | (n != v);
            COND_AL: cond_pass = 1'b1;
            COND_NV: cond_pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/id_exe_stage_reg.sv
// ID/EXE pipeline register: turns failed conditions, hazards and flushes into
// bubbles, freezes on hold, and counts loaded bubbles (saturating).
module id_exe_stage_reg
    import arm_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hold,
    input  logic                  flush,
    input  logic                  hazard,
    input  logic [3:0]            cond,
    input  logic [3:0]            status,
    input  logic [EXEC_CMD_W-1:0] exec_cmd_in,
    input  logic                  mem_r_en_in,
    input  logic                  mem_w_en_in,
    input  logic                  wb_en_in,
    input  logic                  status_w_en_in,
    input  logic                  branch_taken_in,
    input  logic                  imm_in,
    input  logic [WIDTH-1:0]      pc_in,
    input  logic [WIDTH-1:0]      val_rn_in,
    input  logic [WIDTH-1:0]      val_rm_in,
    input  logic [11:0]           shift_operand_in,
    input  logic [23:0]           signed_imm_24_in,
    input  logic [3:0]            dest_in,
    input  logic [3:0]            src1_in,
    input  logic [3:0]            src2_in,
    input  logic                  carry_in,
    output logic [EXEC_CMD_W-1:0] exec_cmd_out,
    output logic                  mem_r_en_out,
    output logic                  mem_w_en_out,
    output logic                  wb_en_out,
    output logic                  status_w_en_out,
    output logic                  branch_taken_out,
    output logic                  imm_out,
    output logic [WIDTH-1:0]      pc_out,
    output logic [WIDTH-1:0]      val_rn_out,
    output logic [WIDTH-1:0]      val_rm_out,
    output logic [11:0]           shift_operand_out,
    output logic [23:0]           signed_imm_24_out,
    output logic [3:0]            dest_out,
    output logic [3:0]            src1_out,
    output logic [3:0]            src2_out,
    output logic                  carry_out,
    output logic                  valid_out,
    output logic [CNT_W-1:0]      bubble_cnt
);

    logic             cond_pass;
    logic             kill;
    ctrl_t            ctrl_in, ctrl_d, ctrl_q;
    logic             valid_d, valid_q;
    logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;

    logic             imm_q, carry_q;
    logic [WIDTH-1:0] pc_q, val_rn_q, val_rm_q;
    logic [11:0]      shift_operand_q;
    logic [23:0]      signed_imm_24_q;
    logic [3:0]       dest_q, src1_q, src2_q;

    cond_check u_cond_check (
        .cond      (cond),
        .status    (status),
        .cond_pass (cond_pass)
    );

    assign kill    = flush | hazard | !cond_pass;
    assign ctrl_in = '{exec_cmd:     exec_cmd_in,
                       mem_r_en:     mem_r_en_in,
                       mem_w_en:     mem_w_en_in,
                       wb_en:        wb_en_in,
                       status_w_en:  status_w_en_in,
                       branch_taken: branch_taken_in};

    // Only control bits are squashed; data fields pass through to aid debug.
    always_comb begin
        ctrl_d       = kill ? '0 : ctrl_in;
        valid_d      = !kill;
        bubble_cnt_d = bubble_cnt_q;
        if (kill && !(&bubble_cnt_q))
            bubble_cnt_d = bubble_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q          <= '0;
            valid_q         <= 1'b0;
            bubble_cnt_q    <= '0;
            imm_q           <= 1'b0;
            carry_q         <= 1'b0;
            pc_q            <= '0;
            val_rn_q        <= '0;
            val_rm_q        <= '0;
            shift_operand_q <= '0;
            signed_imm_24_q <= '0;
            dest_q          <= '0;
            src1_q          <= '0;
            src2_q          <= '0;
        end else if (!hold) begin
            ctrl_q          <= ctrl_d;
            valid_q         <= valid_d;
            bubble_cnt_q    <= bubble_cnt_d;
            imm_q           <= imm_in;
            carry_q         <= carry_in;
            pc_q            <= pc_in;
            val_rn_q        <= val_rn_in;
            val_rm_q        <= val_rm_in;
            shift_operand_q <= shift_operand_in;
            signed_imm_24_q <= signed_imm_24_in;
            dest_q          <= dest_in;
            src1_q          <= src1_in;
            src2_q          <= src2_in;
        end
    end

    assign exec_cmd_out      = ctrl_q.exec_cmd;
    assign mem_r_en_out      = ctrl_q.mem_r_en;
    assign mem_w_en_out      = ctrl_q.mem_w_en;
    assign wb_en_out         = ctrl_q.wb_en;
    assign status_w_en_out   = ctrl_q.status_w_en;
    assign branch_taken_out  = ctrl_q.branch_taken;
    assign imm_out           = imm_q;
    assign carry_out         = carry_q;
    assign pc_out            = pc_q;
    assign val_rn_out        = val_rn_q;
    assign val_rm_out        = val_rm_q;
    assign shift_operand_out = shift_operand_q;
    assign signed_imm_24_out = signed_imm_24_q;
    assign dest_out          = dest_q;
    assign src1_out          = src1_q;
    assign src2_out          = src2_q;
    assign valid_out         = valid_q;
    assign bubble_cnt        = bubble_cnt_q;

endmodule
